// File: rtl/fir_mac_sequencer_pkg.sv
// rtl/fir_mac_sequencer_pkg.sv - shared sizing, address type and FSM encodings for the FIR MAC sequencer
package fir_mac_sequencer_pkg;

   localparam int NTAPS   = 64;
   localparam int ADDR_W  = $clog2(NTAPS);
   localparam int MAC_LAT = 2;
   localparam int FLUSH_W = $clog2(MAC_LAT + 1) + 1;

   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t LAST_TAP = addr_t'(NTAPS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fir_valid_delay.sv
// rtl/fir_valid_delay.sv - delays the {first, valid} address tags by the MAC operand latency
module fir_valid_delay #(
   parameter int LAT = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic addr_valid,
   input  logic addr_first,
   output logic mac_en,
   output logic mac_clear
);

   logic [LAT-1:0] valid_sr;
   logic [LAT-1:0] first_sr;
   logic [LAT:0]   valid_next;
   logic [LAT:0]   first_next;

   // Widened by one bit so the shift stays legal when LAT is 1.
   assign valid_next = {valid_sr, addr_valid};
   assign first_next = {first_sr, addr_first};

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_sr <= '0;
         first_sr <= '0;
      end else begin
         valid_sr <= valid_next[LAT-1:0];
         first_sr <= first_next[LAT-1:0];
      end
   end

   assign mac_en    = valid_sr[LAT-1];
   assign mac_clear = first_sr[LAT-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed tap sequencer driving the shared 8-filter MAC bank
module fir_mac_sequencer
   import fir_mac_sequencer_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              din_enable,
   output logic              busy,
   output logic              sample_we,
   output logic [ADDR_W-1:0] sample_waddr,
   output logic [ADDR_W-1:0] sample_raddr,
   output logic [ADDR_W-1:0] coeffaddress,
   output logic              mac_clear,
   output logic              mac_en,
   output logic              dout_load,
   output logic              overrun
);

   logic [1:0]         state;
   addr_t              wptr;
   addr_t              tap_k;
   addr_t              raddr_q;
   logic [FLUSH_W-1:0] flush_cnt;
   logic               addr_valid;
   logic               addr_first;

   // raddr_q starts at the newest sample (base) and walks backwards one slot per tap.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wptr      <= '0;
         tap_k     <= '0;
         raddr_q   <= '0;
         flush_cnt <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= din_enable & (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (din_enable) begin
                  wptr    <= wptr + addr_t'(1);
                  raddr_q <= wptr;
                  tap_k   <= '0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (tap_k == LAST_TAP) begin
                  tap_k     <= '0;
                  raddr_q   <= '0;
                  flush_cnt <= '0;
                  state     <= ST_FLUSH;
               end else begin
                  tap_k   <= tap_k + addr_t'(1);
                  raddr_q <= raddr_q - addr_t'(1);
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == FLUSH_W'(MAC_LAT)) begin
                  state <= ST_IDLE;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign addr_valid   = (state == ST_RUN);
   assign addr_first   = addr_valid & (tap_k == '0);
   assign busy         = (state != ST_IDLE);
   assign sample_we    = din_enable & reset & (state == ST_IDLE);
   assign sample_waddr = wptr;
   assign sample_raddr = raddr_q;
   assign coeffaddress = tap_k;
   // Last mac_en is one cycle behind us when flush_cnt reaches MAC_LAT.
   assign dout_load    = (state == ST_FLUSH) & (flush_cnt == FLUSH_W'(MAC_LAT));

   fir_valid_delay #(
      .LAT (MAC_LAT)
   ) u_valid_delay (
      .clock      (clock),
      .reset      (reset),
      .addr_valid (addr_valid),
      .addr_first (addr_first),
      .mac_en     (mac_en),
      .mac_clear  (mac_clear)
   );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench: directed vector table plus random stimulus vs behavioural model
module tb_fir_mac_sequencer;
   import fir_mac_sequencer_pkg::*;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              din_enable = 1'b0;
   logic              busy;
   logic              sample_we;
   logic [ADDR_W-1:0] sample_waddr;
   logic [ADDR_W-1:0] sample_raddr;
   logic [ADDR_W-1:0] coeffaddress;
   logic              mac_clear;
   logic              mac_en;
   logic              dout_load;
   logic              overrun;

   fir_mac_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .din_enable   (din_enable),
      .busy         (busy),
      .sample_we    (sample_we),
      .sample_waddr (sample_waddr),
      .sample_raddr (sample_raddr),
      .coeffaddress (coeffaddress),
      .mac_clear    (mac_clear),
      .mac_en       (mac_en),
      .dout_load    (dout_load),
      .overrun      (overrun)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [ADDR_W-1:0] raddr;
      logic [ADDR_W-1:0] coeff;
      logic              clr;
      logic              en;
      logic              dl;
      logic              busy;
      logic              ovr;
   } out_t;

   typedef struct {
      int off;
      int we;
      int waddr;
      int coeff;
      int raddr;
      int clr;
      int en;
      int dl;
      int busy;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   m_acc = -1000;
   int   m_base = 0;
   int   m_wptr = 0;
   bit   m_ovr = 1'b0;
   bit   m_known = 1'b0;
   out_t obs;
   vec_t vt[14];

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endtask

   // One clock: compare against the model, capture outputs, advance the model at the edge.
   task automatic tick();
      out_t e;
      int   d;
      bit   run;
      #1;
      d   = cyc - m_acc;
      run = (d >= 1) && (d <= NTAPS);
      e.busy  = (d >= 1) && (d <= NTAPS + MAC_LAT + 1);
      e.coeff = run ? ADDR_W'(d - 1) : '0;
      e.raddr = run ? ADDR_W'((m_base - (d - 1)) % NTAPS + NTAPS) : '0;
      e.en    = (d >= 1 + MAC_LAT) && (d <= NTAPS + MAC_LAT);
      e.clr   = (d == 1 + MAC_LAT);
      e.dl    = (d == NTAPS + MAC_LAT + 1);
      e.we    = din_enable & reset & ~e.busy;
      e.waddr = ADDR_W'(m_wptr);
      e.ovr   = m_ovr;
      obs = '{sample_we, sample_waddr, sample_raddr, coeffaddress,
              mac_clear, mac_en, dout_load, busy, overrun};
      if (m_known) begin
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL model cyc=%0d {we,waddr,raddr,coeff,clr,en,dl,busy,ovr} got=%b,%0d,%0d,%0d,%b,%b,%b,%b,%b expected=%b,%0d,%0d,%0d,%b,%b,%b,%b,%b",
                     cyc, obs.we, obs.waddr, obs.raddr, obs.coeff, obs.clr, obs.en, obs.dl, obs.busy, obs.ovr,
                     e.we, e.waddr, e.raddr, e.coeff, e.clr, e.en, e.dl, e.busy, e.ovr);
         end
      end
      @(posedge clock);
      if (!reset) begin
         m_acc   = -1000;
         m_wptr  = 0;
         m_ovr   = 1'b0;
         m_known = 1'b1;
      end else begin
         m_ovr = din_enable & e.busy;
         if (din_enable && !e.busy) begin
            m_acc  = cyc;
            m_base = m_wptr;
            m_wptr = (m_wptr + 1) % NTAPS;
         end
      end
      #1;
      cyc++;
   endtask

   initial begin
      bit dl_seen;

      vt[0]  = '{0,  1, 0, 0, 0,  0, 0, 0, 0};
      vt[1]  = '{1,  0, 1, 0, 0,  0, 0, 0, 1};
      vt[2]  = '{2,  0, 1, 1, 63, 0, 0, 0, 1};
      vt[3]  = '{3,  0, 1, 2, 62, 1, 1, 0, 1};
      vt[4]  = '{4,  0, 1, 3, 61, 0, 1, 0, 1};
      vt[5]  = '{64, 0, 1, 63, 1, 0, 1, 0, 1};
      vt[6]  = '{65, 0, 1, 0, 0,  0, 1, 0, 1};
      vt[7]  = '{66, 0, 1, 0, 0,  0, 1, 0, 1};
      vt[8]  = '{67, 0, 1, 0, 0,  0, 0, 1, 1};
      vt[9]  = '{68, 1, 1, 0, 0,  0, 0, 0, 0};
      vt[10] = '{69, 0, 2, 0, 1,  0, 0, 0, 1};
      vt[11] = '{70, 0, 2, 1, 0,  0, 0, 0, 1};
      vt[12] = '{71, 0, 2, 2, 63, 1, 1, 0, 1};
      vt[13] = '{72, 0, 2, 3, 62, 0, 1, 0, 1};

      // Reset held for three cycles, then released idle.
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_waddr", sample_waddr, 0);
      chk("reset_outputs", {sample_we, sample_raddr, coeffaddress, mac_clear, mac_en, dout_load, overrun}, 0);

      // First sweep at T, second sample accepted the cycle busy drops (T+68).
      for (int off = 0; off <= 72; off++) begin
         din_enable = (off == 0) || (off == 68);
         tick();
         for (int i = 0; i < 14; i++) begin
            if (vt[i].off == off) begin
               chk("vec_we", obs.we, vt[i].we);
               chk("vec_waddr", obs.waddr, vt[i].waddr);
               chk("vec_coeff", obs.coeff, vt[i].coeff);
               chk("vec_raddr", obs.raddr, vt[i].raddr);
               chk("vec_clear", obs.clr, vt[i].clr);
               chk("vec_en", obs.en, vt[i].en);
               chk("vec_dload", obs.dl, vt[i].dl);
               chk("vec_busy", obs.busy, vt[i].busy);
            end
         end
      end
      din_enable = 1'b0;
      for (int i = 0; i < 70; i++) tick();

      // Overruns mid-sweep and on the dout_load cycle.
      for (int off = 0; off <= 69; off++) begin
         din_enable = (off == 0) || (off == 10) || (off == 67);
         tick();
         if (off == 0)  begin chk("ovr_accept_we", obs.we, 1); chk("ovr_accept_waddr", obs.waddr, 2); end
         if (off == 10) chk("ovr_we_blocked", obs.we, 0);
         if (off == 11) begin chk("ovr_pulse1", obs.ovr, 1); chk("ovr_waddr_held", obs.waddr, 3); end
         if (off == 12) chk("ovr_single_cycle", obs.ovr, 0);
         if (off == 67) begin chk("ovr_dl_we", obs.we, 0); chk("ovr_dl_timing", obs.dl, 1); end
         if (off == 68) begin chk("ovr_pulse2", obs.ovr, 1); chk("ovr_idle", obs.busy, 0); chk("ovr_waddr_end", obs.waddr, 3); end
         if (off == 69) chk("ovr_clear", obs.ovr, 0);
      end

      // Reset in the middle of a sweep.
      dl_seen = 1'b0;
      for (int off = 0; off <= 120; off++) begin
         din_enable = (off == 0);
         reset = (off != 30);
         tick();
         if (obs.dl) dl_seen = 1'b1;
         if (off == 31) begin
            chk("abort_en", obs.en, 0);
            chk("abort_busy", obs.busy, 0);
            chk("abort_waddr", obs.waddr, 0);
         end
      end
      chk("abort_no_dload", dl_seen, 0);
      din_enable = 1'b1;
      tick();
      chk("abort_next_we", obs.we, 1);
      chk("abort_next_waddr", obs.waddr, 0);
      din_enable = 1'b0;
      for (int i = 0; i < 70; i++) tick();

      // Wrap: 65 accepted samples with random overrun noise during each sweep.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 1; s <= 65; s++) begin
         for (int off = 0; off <= 69; off++) begin
            din_enable = (off == 0) || (off >= 1 && off <= 66 && $urandom_range(0, 9) == 0);
            tick();
            if (s == 65) begin
               if (off == 0)  begin chk("wrap_we", obs.we, 1); chk("wrap_waddr", obs.waddr, 0); end
               if (off == 1)  chk("wrap_raddr0", obs.raddr, 0);
               if (off == 2)  chk("wrap_raddr1", obs.raddr, 63);
               if (off == 64) chk("wrap_raddr63", obs.raddr, 1);
            end
         end
      end

      // Free-running random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         din_enable = ($urandom_range(0, 14) == 0);
         reset = ($urandom_range(0, 399) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
